// File: rtl/gost_sd_crypt_ctrl_pkg.sv
// Shared definitions for the GOST block-buffer crypt controller.
// Holds the cipher word width, the SD block size, the controller state
// encoding and a helper that extracts one byte of a cipher word.
package gost_sd_crypt_ctrl_pkg;

  localparam int unsigned GOST_BLK_W     = 64;
  localparam int unsigned SD_BLOCK_BYTES = 512;
  localparam int unsigned GROUP_BYTES    = GOST_BLK_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_FETCH = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } ctrl_state_t;

  // Byte k of a cipher word; byte 0 is the most significant byte [63:56].
  function automatic logic [7:0] word_byte(input logic [GOST_BLK_W-1:0] w,
                                           input logic [2:0]            k);
    logic [GOST_BLK_W-1:0] s;
    s = w << {k, 3'b000};
    return s[GOST_BLK_W-1 -: 8];
  endfunction

endpackage

// File: rtl/gost_sd_crypt_ctrl.sv
// gost_sd_crypt_ctrl: counter-mode sequencer for one SD block held in the
// 512-byte buffer. Each 8-byte group is read, XORed with E(N) and written
// back in place; N increments per group.
// Optional feature macro: GOST_CTRL_TIMEOUT_EN (adds TIMEOUT_CYC and oerr).
module gost_sd_crypt_ctrl
  import gost_sd_crypt_ctrl_pkg::*;
#(
`ifdef GOST_CTRL_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYC = 1024,
`endif
  parameter int unsigned BLOCK_BYTES = SD_BLOCK_BYTES,
  parameter int unsigned ADDR_W      = 9
) (
  input  logic                  iclk,
  input  logic                  irst,
  input  logic                  istart,
  input  logic [GOST_BLK_W-1:0] iiv,
  output logic [ADDR_W-1:0]     oram_addr,
  output logic                  oram_we,
  output logic [7:0]            oram_wdata,
  input  logic [7:0]            iram_rdata,
  output logic                  ogost_start,
  output logic [GOST_BLK_W-1:0] ogost_block,
  input  logic                  igost_done,
  input  logic [GOST_BLK_W-1:0] igost_result,
  output logic                  obusy,
`ifdef GOST_CTRL_TIMEOUT_EN
  output logic                  oerr,
`endif
  output logic                  odone
);

  localparam logic [ADDR_W-1:0] LAST_BASE = ADDR_W'(BLOCK_BYTES - GROUP_BYTES);

  ctrl_state_t           state_q, state_d;
  logic [GOST_BLK_W-1:0] n_q;
  logic [ADDR_W-1:0]     base_q;
  logic [3:0]            fcnt_q;
  logic [2:0]            wcnt_q;
  logic [7:0]            dbuf_q [GROUP_BYTES];
  logic [GOST_BLK_W-1:0] gamma_q;
  logic                  gamma_vld_q;
  logic                  fetch_ready;

  // Fetch issues addresses on FETCH cycles 0..7 and captures data on 1..8,
  // so all bytes are in once fcnt reaches 8; gamma must be registered first.
  assign fetch_ready = (fcnt_q >= 4'd8) && gamma_vld_q;
  assign ogost_block = n_q;

`ifdef GOST_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            oerr_q;
  logic            timeout_hit;

  assign timeout_hit = (state_q == ST_FETCH) && !gamma_vld_q && !igost_done &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));
  assign oerr = oerr_q;

  // Cipher-wait watchdog and sticky error flag, cleared by the next accepted start.
  always_ff @(posedge iclk) begin
    if (irst) begin
      to_cnt_q <= '0;
      oerr_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && istart) oerr_q <= 1'b0;
      if (state_q == ST_START) to_cnt_q <= '0;
      if (state_q == ST_FETCH) to_cnt_q <= to_cnt_q + 1'b1;
      if (timeout_hit) oerr_q <= 1'b1;
    end
  end
`endif

  // State register.
  always_ff @(posedge iclk) begin
    if (irst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic and all control/buffer-port outputs.
  always_comb begin
    state_d     = state_q;
    ogost_start = 1'b0;
    oram_we     = 1'b0;
    oram_wdata  = '0;
    oram_addr   = '0;
    obusy       = (state_q != ST_IDLE);
    odone       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (istart) state_d = ST_START;
      end
      ST_START: begin
        ogost_start = 1'b1;
        oram_addr   = base_q;
        state_d     = ST_FETCH;
      end
      ST_FETCH: begin
        // Low three bits keep the address inside the group while waiting.
        oram_addr = base_q + ADDR_W'(fcnt_q[2:0]);
        if (fetch_ready) state_d = ST_WRITE;
`ifdef GOST_CTRL_TIMEOUT_EN
        else if (timeout_hit) state_d = ST_FIN;
`endif
      end
      ST_WRITE: begin
        oram_we    = 1'b1;
        oram_addr  = base_q + ADDR_W'(wcnt_q);
        oram_wdata = dbuf_q[wcnt_q] ^ word_byte(gamma_q, wcnt_q);
        if (wcnt_q == 3'd7) state_d = (base_q == LAST_BASE) ? ST_FIN : ST_START;
      end
      ST_FIN: begin
        odone   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Counter, group base, fetch/write indices, byte buffer and gamma capture.
  always_ff @(posedge iclk) begin
    if (irst) begin
      n_q         <= '0;
      base_q      <= '0;
      fcnt_q      <= '0;
      wcnt_q      <= '0;
      gamma_q     <= '0;
      gamma_vld_q <= 1'b0;
      for (int unsigned i = 0; i < GROUP_BYTES; i++) dbuf_q[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (istart) begin
            n_q    <= iiv;
            base_q <= '0;
          end
        end
        ST_START: begin
          fcnt_q      <= '0;
          wcnt_q      <= '0;
          gamma_vld_q <= 1'b0;
        end
        ST_FETCH: begin
          if (fcnt_q != 4'd9) fcnt_q <= fcnt_q + 4'd1;
          if (fcnt_q != 4'd0 && fcnt_q <= 4'd8)
            dbuf_q[fcnt_q[2:0] - 3'd1] <= iram_rdata;
          if (igost_done && !gamma_vld_q) begin
            gamma_q     <= igost_result;
            gamma_vld_q <= 1'b1;
          end
        end
        ST_WRITE: begin
          wcnt_q <= wcnt_q + 3'd1;
          if (wcnt_q == 3'd7) begin
            n_q    <= n_q + 1'b1;
            base_q <= base_q + ADDR_W'(GROUP_BYTES);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gost_sd_crypt_ctrl.sv
// Self-checking bench for gost_sd_crypt_ctrl: registered RAM model, cipher
// model with programmable latency/result, table of block runs plus directed
// reset, busy-start and (with GOST_CTRL_TIMEOUT_EN) timeout sequences.
`timescale 1ns/1ps
module tb_gost_sd_crypt_ctrl;

  localparam int BB = 512;
  localparam int AW = 9;
  localparam int TO = 40;

  logic          iclk = 1'b0;
  logic          irst = 1'b1;
  logic          istart = 1'b0;
  logic [63:0]   iiv = '0;
  logic [AW-1:0] oram_addr;
  logic          oram_we;
  logic [7:0]    oram_wdata;
  logic [7:0]    iram_rdata = '0;
  logic          ogost_start;
  logic [63:0]   ogost_block;
  logic          igost_done = 1'b0;
  logic [63:0]   igost_result = '0;
  logic          obusy;
  logic          odone;
`ifdef GOST_CTRL_TIMEOUT_EN
  logic          oerr;
`endif

  gost_sd_crypt_ctrl #(
`ifdef GOST_CTRL_TIMEOUT_EN
    .TIMEOUT_CYC(TO),
`endif
    .BLOCK_BYTES(BB),
    .ADDR_W(AW)
  ) dut (
    .iclk(iclk), .irst(irst), .istart(istart), .iiv(iiv),
    .oram_addr(oram_addr), .oram_we(oram_we), .oram_wdata(oram_wdata),
    .iram_rdata(iram_rdata), .ogost_start(ogost_start), .ogost_block(ogost_block),
    .igost_done(igost_done), .igost_result(igost_result), .obusy(obusy),
`ifdef GOST_CTRL_TIMEOUT_EN
    .oerr(oerr),
`endif
    .odone(odone)
  );

  always #5 iclk = ~iclk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  // RAM model (registered read) with bulk load of a seeded pattern.
  int   seed = 0;
  logic ram_load = 1'b0;
  logic [7:0] mem [BB];

  function automatic logic [7:0] init_byte(input int a, input int s);
    return 8'((a * 13 + s * 7) ^ (a >> 3));
  endfunction

  always @(posedge iclk) begin
    if (ram_load) begin
      for (int a = 0; a < BB; a++) mem[a] <= init_byte(a, seed);
    end else begin
      if (oram_we) mem[oram_addr] <= oram_wdata;
      iram_rdata <= mem[oram_addr];
    end
  end

  // Cipher model: mode 0 -> result 0, 1 -> ~N, 2 -> never answers.
  // dup adds a second, bogus done two cycles after the first.
  int  mdl_mode = 0;
  int  mdl_lat = 1;
  bit  mdl_dup = 0;
  int  m_cnt, m_cnt2;
  bit  m_pend = 0, m_pend2 = 0;
  logic [63:0] m_blk;
  always @(negedge iclk) begin
    igost_done = 1'b0;
    if (irst) begin
      m_pend = 0; m_pend2 = 0;
    end else begin
      if (ogost_start) begin
        m_pend = 1; m_cnt = mdl_lat; m_blk = ogost_block;
      end else if (m_pend) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_pend = 0;
          if (mdl_mode != 2) begin
            igost_done   = 1'b1;
            igost_result = (mdl_mode == 1) ? ~m_blk : 64'h0;
            if (mdl_dup) begin m_pend2 = 1; m_cnt2 = 2; end
          end
        end
      end
      if (m_pend2 && !igost_done) begin
        m_cnt2--;
        if (m_cnt2 == 0) begin
          m_pend2      = 0;
          igost_done   = 1'b1;
          igost_result = 64'hDEAD_BEEF_0BAD_F00D;
        end
      end
    end
  end

  // Monitor: start/done log, write count, read-before-write tracking.
  logic mon_clr = 1'b0;
  int   nstart, ndone, nwr, rbw_bad, done_cyc;
  int   st_cyc [2];
  logic [63:0] blk_log [64];
  bit   rd_seen [BB];
  always @(negedge iclk) begin
    if (mon_clr) begin
      nstart = 0; ndone = 0; nwr = 0; rbw_bad = 0; done_cyc = 0;
      for (int a = 0; a < BB; a++) rd_seen[a] = 0;
    end else begin
      if (ogost_start) begin
        if (nstart < 64) blk_log[nstart] = ogost_block;
        if (nstart < 2) st_cyc[nstart] = cyc;
        nstart++;
      end
      if (odone) begin ndone++; done_cyc = cyc; end
      if (obusy && !oram_we && !ogost_start) rd_seen[oram_addr] = 1;
      if (oram_we) begin
        nwr++;
        if (!rd_seen[oram_addr]) rbw_bad++;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic prep(input int s);
    seed = s;
    @(negedge iclk); #1 ram_load = 1'b1; mon_clr = 1'b1;
    @(negedge iclk); #1 ram_load = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [63:0] iv);
    @(negedge iclk); #1 iiv = iv; istart = 1'b1;
    @(posedge iclk); #1 istart = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit finished);
    finished = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge iclk); #1;
      if (ndone > 0) begin finished = 1; break; end
    end
    repeat (3) @(negedge iclk);
    #1;
  endtask

  typedef struct {
    logic [63:0] iv;
    int          mode;
    int          lat;
    bit          dup;
    int          period;
    logic [63:0] n1;
    bit          ffchk;
  } vec_t;

  vec_t vt [6];

  initial begin
    bit fin;
    int mis;
    logic [63:0] gam;
    logic [7:0]  eb;

    vt[0] = '{64'h0123_4567_89AB_CDEF, 0, 20, 0, 30, 64'h0123_4567_89AB_CDF0, 0};
    vt[1] = '{64'h0,                   1, 20, 1, 30, 64'h1,                   1};
    vt[2] = '{64'h1000,                1,  1, 0, 18, 64'h1001,                0};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 1,  5, 0, 18, 64'h0,                   0};
    vt[4] = '{64'hA5A5_A5A5_A5A5_A5A5, 1,  3, 1, 18, 64'hA5A5_A5A5_A5A5_A5A6, 0};
    vt[5] = '{64'h0000_0000_FFFF_FFFF, 1, 12, 0, 22, 64'h0000_0001_0000_0000, 0};

    // Reset state.
    irst = 1'b1;
    repeat (3) @(negedge iclk);
    chk("rst_busy", obusy, 0);
    chk("rst_done", odone, 0);
    chk("rst_we", oram_we, 0);
    chk("rst_gstart", ogost_start, 0);
    chk("rst_block", ogost_block, 0);
    chk("rst_wdata", oram_wdata, 0);
    chk("rst_addr", oram_addr, 0);
`ifdef GOST_CTRL_TIMEOUT_EN
    chk("rst_err", oerr, 0);
`endif
    #1 irst = 1'b0;

    // Table of whole-block runs.
    for (int v = 0; v < 6; v++) begin
      mdl_mode = vt[v].mode; mdl_lat = vt[v].lat; mdl_dup = vt[v].dup;
      prep(v * 37 + 1);
      pulse_start(vt[v].iv);
      wait_done(4000, fin);
      chk($sformatf("v%0d_finish", v), fin, 1);
      chk($sformatf("v%0d_ndone", v), ndone, 1);
      chk($sformatf("v%0d_nstart", v), nstart, 64);
      chk($sformatf("v%0d_nwr", v), nwr, BB);
      chk($sformatf("v%0d_rbw", v), rbw_bad, 0);
      chk($sformatf("v%0d_period", v), st_cyc[1] - st_cyc[0], vt[v].period);
      chk($sformatf("v%0d_n1", v), blk_log[1], vt[v].n1);
      mis = 0;
      for (int i = 0; i < 64; i++) if (blk_log[i] !== vt[v].iv + 64'(i)) mis++;
      chk($sformatf("v%0d_blkseq", v), mis, 0);
      mis = 0;
      for (int a = 0; a < BB; a++) begin
        gam = (vt[v].mode == 1) ? ~(vt[v].iv + 64'(a / 8)) : 64'h0;
        eb  = init_byte(a, seed) ^ 8'(gam >> (8 * (7 - (a % 8))));
        if (mem[a] !== eb) mis++;
      end
      chk($sformatf("v%0d_ram", v), mis, 0);
      if (vt[v].ffchk) begin
        for (int k = 0; k < 8; k++)
          chk($sformatf("v%0d_g0b%0d", v, k), mem[k], init_byte(k, seed) ^ 8'hFF);
      end
`ifdef GOST_CTRL_TIMEOUT_EN
      chk($sformatf("v%0d_err", v), oerr, 0);
`endif
    end

    // Reset during the WRITE of group 3, then restart.
    mdl_mode = 1; mdl_lat = 20; mdl_dup = 0;
    prep(99);
    pulse_start(64'h55);
    fin = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge iclk); #1;
      if (nstart >= 4 && oram_we) begin fin = 1; break; end
    end
    chk("rst3_reached", fin, 1);
    irst = 1'b1;
    @(posedge iclk); #1;
    chk("rst3_we", oram_we, 0);
    chk("rst3_busy", obusy, 0);
    chk("rst3_gstart", ogost_start, 0);
    chk("rst3_done", odone, 0);
    @(negedge iclk); #1 irst = 1'b0;
    prep(100);
    pulse_start(64'h77);
    fin = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge iclk);
      if (ogost_start) begin fin = 1; break; end
    end
    chk("rst3_restart", fin, 1);
    chk("rst3_block", ogost_block, 64'h77);
    @(negedge iclk);
    chk("rst3_addr0", oram_addr, 0);
    wait_done(4000, fin);
    chk("rst3_finish", fin, 1);
    chk("rst3_ndone", ndone, 1);

    // istart while busy and coincident with odone is ignored.
    mdl_mode = 0; mdl_lat = 4; mdl_dup = 0;
    prep(7);
    pulse_start(64'h100);
    repeat (100) @(negedge iclk);
    pulse_start(64'hBAD);
    fin = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge iclk);
      if (odone) begin fin = 1; break; end
    end
    chk("busy_done_seen", fin, 1);
    istart = 1'b1; iiv = 64'hBAD;
    @(posedge iclk); #1 istart = 1'b0;
    chk("busy_coinc_idle", obusy, 0);
    repeat (30) @(negedge iclk);
    #1;
    chk("busy_nstart", nstart, 64);
    chk("busy_ndone", ndone, 1);
    chk("busy_blk0", blk_log[0], 64'h100);
    chk("busy_blk63", blk_log[63], 64'h100 + 64'd63);
    mis = 0;
    for (int a = 0; a < BB; a++) if (mem[a] !== init_byte(a, seed)) mis++;
    chk("busy_ram", mis, 0);

`ifdef GOST_CTRL_TIMEOUT_EN
    // Cipher never answers: timeout error then recovery.
    mdl_mode = 2; mdl_lat = 5; mdl_dup = 0;
    prep(11);
    pulse_start(64'h0);
    wait_done(500, fin);
    chk("to_finish", fin, 1);
    chk("to_err", oerr, 1);
    chk("to_nstart", nstart, 1);
    chk("to_ndone", ndone, 1);
    chk("to_latency", done_cyc - st_cyc[0], TO + 1);
    mdl_mode = 0; mdl_lat = 2;
    prep(12);
    pulse_start(64'h9);
    chk("to_err_clr", oerr, 0);
    wait_done(4000, fin);
    chk("to_recover", fin, 1);
    chk("to_err_after", oerr, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
